// File: rtl/eth_phy_mdio_init.sv
// Purpose : boot-time RGMII PHY bring-up. Holds the PHY in reset, releases it, reads PHY ID1
//           over MDIO and then issues a table of MDIO writes. Afterwards the MDC/MDIO pins are
//           handed to the SoC Ethernet MAC through an output mux.
// Latency : RstHoldCycles + RstWaitCycles + (1 + NumWrites) * (64 + 1) * 2 * ClkDiv + 1 cycles to DONE.
// Backpr. : none; the sequence is free-running. restart_i is honoured only in DONE or ERROR.
// Ports   : soc_clk/rst_n clock and async active-low reset; restart_i re-run pulse;
//           phy_rst_no PHY reset; mdc_o/mdio_o/mdio_oe_o/mdio_i pad side of the MDIO IOBUF;
//           soc_mdc_i/soc_mdio_o_i/soc_mdio_oe_i/soc_mdio_i_o SoC MAC side;
//           busy_o/done_o/err_o status; phy_id_o last PHY ID1 value read.
module eth_phy_mdio_init #(
    parameter int                     ClkDiv        = 25,
    parameter int                     RstHoldCycles = 500000,
    parameter int                     RstWaitCycles = 250000,
    parameter logic [4:0]             PhyAddr       = 5'd0,
    parameter int                     NumWrites     = 2,
    parameter logic [NumWrites*21-1:0] InitTable    = {5'h10, 16'h0000, 5'h00, 16'h1140}
) (
    input  logic        soc_clk,
    input  logic        rst_n,
    input  logic        restart_i,
    output logic        phy_rst_no,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i,
    input  logic        soc_mdc_i,
    input  logic        soc_mdio_o_i,
    input  logic        soc_mdio_oe_i,
    output logic        soc_mdio_i_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] phy_id_o
);

    localparam int RstMax = (RstHoldCycles > RstWaitCycles) ? RstHoldCycles : RstWaitCycles;
    localparam int RW     = (RstMax > 1)    ? $clog2(RstMax)    : 1;
    localparam int DW     = (ClkDiv > 1)    ? $clog2(ClkDiv)    : 1;
    localparam int IW     = (NumWrites > 1) ? $clog2(NumWrites) : 1;

    localparam logic [RW-1:0] HoldLast = RW'(RstHoldCycles - 1);
    localparam logic [RW-1:0] WaitLast = RW'(RstWaitCycles - 1);
    localparam logic [DW-1:0] DivLast  = DW'(ClkDiv - 1);
    localparam logic [IW-1:0] IdxLast  = IW'(NumWrites - 1);

    // Read of register 2 (PHY ID1). TA and data positions are ones; the bus is released there.
    localparam logic [63:0] ReadFrame = {32'hFFFF_FFFF, 2'b01, 2'b10, PhyAddr, 5'd2, 2'b11, 16'hFFFF};

    typedef enum logic [2:0] {
        RST_HOLD,
        RST_WAIT,
        READ_ID,
        CHECK,
        WRITE,
        DONE,
        ERROR
    } state_t;

    function automatic logic [63:0] write_frame(input logic [IW-1:0] idx);
        logic [20:0] ent;
        ent = InitTable[21*int'(idx) +: 21];
        return {32'hFFFF_FFFF, 2'b01, 2'b01, PhyAddr, ent[20:16], 2'b10, ent[15:0]};
    endfunction

    state_t        state;
    logic [RW-1:0] rst_cnt;
    logic [DW-1:0] div_cnt;
    logic [5:0]    bit_cnt;
    logic [IW-1:0] wr_idx;
    logic [63:0]   tx_sr;     // bit on the wire is tx_sr[63]; ones shift in behind it
    logic [15:0]   rx_sr;     // last 16 sampled bits = data bits 48..63 at frame end
    logic          tail;      // idle MDC period after bit 63
    logic          tail_ph;   // which half of the idle period we are in
    logic          mdc_q;
    logic          oe_q;
    logic          phy_rst_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [15:0]   phy_id_q;

    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_HOLD;
            rst_cnt   <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            wr_idx    <= '0;
            tx_sr     <= '1;
            rx_sr     <= '0;
            tail      <= 1'b0;
            tail_ph   <= 1'b0;
            mdc_q     <= 1'b0;
            oe_q      <= 1'b0;
            phy_rst_q <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            phy_id_q  <= '0;
        end else begin
            case (state)
                RST_HOLD: begin
                    if (rst_cnt == HoldLast) begin
                        state     <= RST_WAIT;
                        rst_cnt   <= '0;
                        phy_rst_q <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                RST_WAIT: begin
                    if (rst_cnt == WaitLast) begin
                        // Bit 0 goes on the wire now, ClkDiv cycles ahead of the first rising MDC.
                        state   <= READ_ID;
                        rst_cnt <= '0;
                        tx_sr   <= ReadFrame;
                        oe_q    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        mdc_q   <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                READ_ID, WRITE: begin
                    if (div_cnt != DivLast) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (tail) begin
                            tail_ph <= ~tail_ph;
                            if (tail_ph) begin
                                tail    <= 1'b0;
                                tail_ph <= 1'b0;
                                bit_cnt <= '0;
                                if (state == READ_ID) begin
                                    state <= CHECK;
                                end else if (wr_idx == IdxLast) begin
                                    state  <= DONE;
                                    done_q <= 1'b1;
                                    busy_q <= 1'b0;
                                end else begin
                                    wr_idx <= wr_idx + IW'(1);
                                    tx_sr  <= write_frame(wr_idx + IW'(1));
                                    oe_q   <= 1'b1;
                                end
                            end
                        end else begin
                            mdc_q <= ~mdc_q;
                            if (!mdc_q) begin
                                // Rising MDC: sample what the PHY drives.
                                rx_sr <= {rx_sr[14:0], mdio_i};
                            end else if (bit_cnt == 6'd63) begin
                                tail  <= 1'b1;
                                oe_q  <= 1'b0;
                                tx_sr <= '1;
                                if (state == READ_ID) begin
                                    phy_id_q <= rx_sr;
                                end
                            end else begin
                                // Falling MDC: present the next bit. A read releases the bus from TA on.
                                bit_cnt <= bit_cnt + 6'd1;
                                tx_sr   <= {tx_sr[62:0], 1'b1};
                                oe_q    <= !((state == READ_ID) && (bit_cnt >= 6'd45));
                            end
                        end
                    end
                end

                CHECK: begin
                    if (phy_id_q == 16'h0000 || phy_id_q == 16'hFFFF) begin
                        state  <= ERROR;
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        state   <= WRITE;
                        wr_idx  <= '0;
                        tx_sr   <= write_frame('0);
                        oe_q    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        mdc_q   <= 1'b0;
                    end
                end

                DONE, ERROR: begin
                    if (restart_i) begin
                        state     <= RST_HOLD;
                        rst_cnt   <= '0;
                        phy_rst_q <= 1'b0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        mdc_q     <= 1'b0;
                        oe_q      <= 1'b0;
                        tx_sr     <= '1;
                    end
                end

                default: state <= RST_HOLD;
            endcase
        end
    end

    // Once DONE the SoC MAC owns the pads; the mux is combinational so MAC timing is untouched.
    assign mdc_o        = (state == DONE) ? soc_mdc_i     : mdc_q;
    assign mdio_o       = (state == DONE) ? soc_mdio_o_i  : tx_sr[63];
    assign mdio_oe_o    = (state == DONE) ? soc_mdio_oe_i : oe_q;
    assign soc_mdio_i_o = mdio_i;
    assign phy_rst_no   = phy_rst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign phy_id_o     = phy_id_q;

endmodule

// File: tb/tb_eth_phy_mdio_init.sv
// Bench for eth_phy_mdio_init: PHY model answers the ID read, a monitor decodes every MDIO
// frame on rising MDC, and directed scenarios cover boot, no-PHY, handover, restart and async reset.
module tb_eth_phy_mdio_init;

    localparam logic [45:0] ReadHdr = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd3, 5'd2};
    localparam logic [63:0] ReadOe  = {{46{1'b1}}, 18'd0};
    localparam logic [63:0] Wr0     = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd3, 5'd0,  2'b10, 16'h1140};
    localparam logic [63:0] Wr1     = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd3, 5'd16, 2'b10, 16'h0000};
    localparam logic [6:0]  RstVec  = 7'b0010100; // {phy_rst_no,mdc,mdio,oe,busy,done,err}

    logic        soc_clk = 1'b0;
    logic        rst_n;
    logic        restart_i;
    logic        phy_rst_no, mdc_o, mdio_o, mdio_oe_o, mdio_i;
    logic        soc_mdc_i, soc_mdio_o_i, soc_mdio_oe_i, soc_mdio_i_o;
    logic        busy_o, done_o, err_o;
    logic [15:0] phy_id_o;

    logic        phy_present, ovr_en, ovr_val;
    logic [15:0] id_word;
    logic [63:0] phy_img;
    logic [5:0]  bcnt = '0;
    logic        mdc_prev = 1'b0;
    logic [63:0] cur_frame = '0, cur_oe = '0;
    int          cyc = 0, last_rise = 0;
    logic [63:0] frames[$];
    logic [63:0] oes[$];
    int          gaps[$];

    int n_checks = 0, n_pass = 0;

    always #5 soc_clk = ~soc_clk;
    always @(posedge soc_clk) cyc <= cyc + 1;

    eth_phy_mdio_init #(
        .ClkDiv(2), .RstHoldCycles(10), .RstWaitCycles(5), .PhyAddr(5'd3)
    ) dut (
        .soc_clk(soc_clk), .rst_n(rst_n), .restart_i(restart_i),
        .phy_rst_no(phy_rst_no), .mdc_o(mdc_o), .mdio_o(mdio_o), .mdio_oe_o(mdio_oe_o),
        .mdio_i(mdio_i), .soc_mdc_i(soc_mdc_i), .soc_mdio_o_i(soc_mdio_o_i),
        .soc_mdio_oe_i(soc_mdio_oe_i), .soc_mdio_i_o(soc_mdio_i_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .phy_id_o(phy_id_o)
    );

    // PHY model: drives ID1 on data bits 48..63 of each frame, otherwise leaves the line pulled up.
    assign phy_img = phy_present ? {48'hFFFF_FFFF_FFFF, id_word} : '1;
    assign mdio_i  = ovr_en ? ovr_val : phy_img[6'd63 - bcnt];

    // Frame monitor: captures mdio_o/mdio_oe_o at each rising MDC while the sequencer owns the pins.
    always @(negedge soc_clk) begin
        if (!rst_n) begin
            bcnt     <= '0;
            mdc_prev <= 1'b0;
        end else begin
            mdc_prev <= mdc_o;
            if (busy_o && mdc_o && !mdc_prev) begin
                cur_frame[6'd63 - bcnt] <= mdio_o;
                cur_oe[6'd63 - bcnt]    <= mdio_oe_o;
                last_rise <= cyc;
                if (bcnt == 6'd0) gaps.push_back(cyc - last_rise);
                if (bcnt == 6'd63) begin
                    frames.push_back({cur_frame[63:1], mdio_o});
                    oes.push_back({cur_oe[63:1], mdio_oe_o});
                end
                bcnt <= bcnt + 6'd1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge soc_clk);
        #1;
    endtask

    task automatic wait_end(input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done_o || err_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bit(input int nfr, input logic [5:0] b, input int bound, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (frames.size() == nfr && bcnt == b) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_restart();
        restart_i = 1'b1;
        tick();
        restart_i = 1'b0;
    endtask

    initial begin
        int   n;
        logic ok, busy_ok, quiet;

        rst_n = 1'b0; restart_i = 1'b0;
        soc_mdc_i = 1'b0; soc_mdio_o_i = 1'b0; soc_mdio_oe_i = 1'b0;
        ovr_en = 1'b0; ovr_val = 1'b0; phy_present = 1'b1; id_word = 16'h0141;

        repeat (3) tick();
        check_val("reset_pins", 64'({phy_rst_no, mdc_o, mdio_o, mdio_oe_o, busy_o, done_o, err_o}), 64'(RstVec));
        check_val("reset_phy_id", 64'(phy_id_o), 64'd0);

        // Boot timing
        rst_n = 1'b1;
        n = 0; busy_ok = 1'b1;
        do begin tick(); n++; if (!busy_o) busy_ok = 1'b0; end while (!phy_rst_no && n < 100);
        check_val("rst_hold_cycles", 64'(n), 64'd10);
        n = 0;
        do begin tick(); n++; if (!busy_o) busy_ok = 1'b0; end while (!mdc_o && n < 100);
        check_val("first_mdc_rise", 64'(n), 64'd7);
        check_val("busy_during_boot", 64'(busy_ok), 64'd1);

        // Full sequence with PHY present
        wait_end(3000, ok);
        check_val("seq1_end", 64'(ok), 64'd1);
        check_val("seq1_frames", 64'(frames.size()), 64'd3);
        if (frames.size() == 3) begin
            check_val("read_hdr", 64'(frames[0][63:18]), 64'(ReadHdr));
            check_val("read_oe", oes[0], ReadOe);
            check_val("write0", frames[1], Wr0);
            check_val("write0_oe", oes[1], 64'hFFFF_FFFF_FFFF_FFFF);
            check_val("write1", frames[2], Wr1);
            check_val("write1_oe", oes[2], 64'hFFFF_FFFF_FFFF_FFFF);
        end
        if (gaps.size() == 3) check_val("write_gap", 64'(gaps[2]), 64'd8);
        check_val("phy_id", 64'(phy_id_o), 64'h0141);
        check_val("done_status", 64'({done_o, busy_o, err_o}), 64'b100);

        // Handover: pins copy SoC in the same cycle
        soc_mdc_i = 1'b1; soc_mdio_o_i = 1'b0; soc_mdio_oe_i = 1'b1; ovr_en = 1'b1; ovr_val = 1'b0;
        #1;
        check_val("handover_a", 64'({mdc_o, mdio_o, mdio_oe_o, soc_mdio_i_o}), 64'b1010);
        soc_mdc_i = 1'b0; soc_mdio_o_i = 1'b1; soc_mdio_oe_i = 1'b0; ovr_val = 1'b1;
        #1;
        check_val("handover_b", 64'({mdc_o, mdio_o, mdio_oe_o, soc_mdio_i_o}), 64'b0101);
        ovr_en = 1'b0;

        // Restart from DONE; a restart mid-frame is ignored
        frames.delete(); oes.delete(); gaps.delete();
        pulse_restart();
        check_val("restart_from_done", 64'({phy_rst_no, done_o, busy_o}), 64'b001);
        wait_bit(1, 6'd10, 3000, ok);
        check_val("seq2_reach_write", 64'(ok), 64'd1);
        pulse_restart();
        check_val("restart_ignored", 64'({phy_rst_no, busy_o}), 64'b11);
        wait_end(3000, ok);
        check_val("seq2_end", 64'(ok), 64'd1);
        check_val("seq2_frames", 64'(frames.size()), 64'd3);
        if (frames.size() == 3) check_val("seq2_write1", frames[2], Wr1);
        check_val("seq2_done", 64'(done_o), 64'd1);

        // No PHY: line stays high
        phy_present = 1'b0;
        frames.delete(); oes.delete(); gaps.delete();
        pulse_restart();
        wait_end(3000, ok);
        check_val("nophy_end", 64'(ok), 64'd1);
        check_val("nophy_id", 64'(phy_id_o), 64'hFFFF);
        check_val("nophy_status", 64'({err_o, done_o, busy_o}), 64'b100);
        quiet = 1'b1;
        repeat (40) begin
            tick();
            if (mdc_o || mdio_oe_o || !phy_rst_no) quiet = 1'b0;
        end
        check_val("error_pins_quiet", 64'(quiet), 64'd1);
        check_val("nophy_frames", 64'(frames.size()), 64'd1);

        // Restart from ERROR, then async reset in the middle of the first write frame
        phy_present = 1'b1;
        frames.delete(); oes.delete(); gaps.delete();
        pulse_restart();
        check_val("err_clear", 64'({err_o, phy_rst_no}), 64'b00);
        check_val("phy_id_kept", 64'(phy_id_o), 64'hFFFF);
        wait_bit(1, 6'd30, 3000, ok);
        check_val("reach_bit30", 64'(ok), 64'd1);
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_pins", 64'({phy_rst_no, mdc_o, mdio_o, mdio_oe_o, busy_o, done_o, err_o}), 64'(RstVec));
        check_val("async_rst_phy_id", 64'(phy_id_o), 64'd0);
        tick(); tick();
        frames.delete(); oes.delete(); gaps.delete();
        rst_n = 1'b1;
        wait_end(3000, ok);
        check_val("seq5_end", 64'(ok), 64'd1);
        check_val("seq5_frames", 64'(frames.size()), 64'd3);
        if (frames.size() == 3) check_val("seq5_write0", frames[1], Wr0);
        check_val("seq5_phy_id", 64'(phy_id_o), 64'h0141);
        check_val("seq5_done", 64'(done_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_phy_mdio_init.md
Name: eth_phy_mdio_init

Overview:
- Boot-time configuration sequencer for the off-chip RGMII Ethernet PHY on FPGA targets.
- Holds the PHY in reset, releases it, then reads PHY ID1 over MDIO to confirm a PHY is present.
- Issues a parameterised list of MDIO register writes.
- After that, hands the MDC/MDIO pins to the SoC Ethernet peripheral through an output mux.
- Sits between the SoC MDIO signals and the MDIO IOBUF.

Parameters:
- ClkDiv, 25: soc_clk cycles per MDC half-period (50 MHz soc_clk gives 1 MHz MDC); must be >=1.
- RstHoldCycles, 500000: soc_clk cycles phy_rst_no is held low (10 ms); must be >=1.
- RstWaitCycles, 250000: soc_clk cycles between reset release and the first frame (5 ms); must be >=1.
- PhyAddr, 5'd0: PHY MDIO address.
- NumWrites, 2: number of init write entries; must be >=1.
- InitTable, {5'h10,16'h0000, 5'h00,16'h1140}: packed NumWrites*21 bits. Entry i is bits [21*i+20:21*i] = {regad[4:0], data[15:0]}. Entry 0 is issued first.

Ports:
- soc_clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- restart_i  in  1  one-cycle pulse; re-runs the sequence from DONE or ERROR
- phy_rst_no  out  1  PHY hardware reset, active-low
- mdc_o  out  1  MDC to pad
- mdio_o  out  1  MDIO output to IOBUF
- mdio_oe_o  out  1  MDIO output enable to IOBUF
- mdio_i  in  1  MDIO input from IOBUF
- soc_mdc_i  in  1  SoC MDC
- soc_mdio_o_i  in  1  SoC MDIO output
- soc_mdio_oe_i  in  1  SoC MDIO output enable
- soc_mdio_i_o  out  1  MDIO input to SoC; combinational copy of mdio_i at all times
- busy_o  out  1  high in every state except DONE and ERROR
- done_o  out  1  sequence completed; SoC owns the pins
- err_o  out  1  PHY ID check failed
- phy_id_o  out  16  last PHY ID1 value read

Behaviour:
- Reset values (rst_n low): state RST_HOLD, phy_rst_no=0, mdc_o=0, mdio_o=1, mdio_oe_o=0, busy_o=1, done_o=0, err_o=0, phy_id_o=0. All counters are 0.
- RST_HOLD: phy_rst_no=0. After exactly RstHoldCycles cycles in this state -> RST_WAIT.
- RST_WAIT: phy_rst_no=1. After RstWaitCycles cycles -> READ_ID.
- Frame format, 64 bits, MSB first:
  - 32 preamble ones
  - ST=01
  - OP=10 (read) or 01 (write)
  - PHYAD[4:0], REGAD[4:0]
  - TA: write drives 10; read releases the bus
  - DATA[15:0]
- MDC timing: generated only during frames; idle level 0.
  - A divider counts 0..ClkDiv-1; mdc_o toggles when it wraps. MDC period = 2*ClkDiv cycles.
  - The block updates mdio_o/mdio_oe_o on every falling edge it generates; bit 0 is presented ClkDiv cycles before the first rising edge.
  - mdio_i is sampled in the soc_clk cycle where mdc_o goes 0->1.
- Bit counter runs 0..63. After bit 63's falling edge, one idle MDC period follows with mdio_oe_o=0 and mdc_o held 0, then the next state.
- READ_ID frame: REGAD=2.
  - mdio_oe_o=1 for bits 0..45 and 0 for bits 46..63.
  - Data bits 48..63 are shifted into phy_id_o MSB first. phy_id_o updates at the end of the frame.
  - Then -> CHECK.
- CHECK: one cycle.
  - phy_id_o==16'h0000 or 16'hFFFF -> ERROR.
  - Otherwise -> WRITE with index 0.
- WRITE: mdio_oe_o=1 for all 64 bits.
  - Index advances after each frame plus its idle period.
  - The frame for index NumWrites-1 completes -> DONE.
- DONE: done_o=1, busy_o=0. Pins follow the SoC combinationally: mdc_o=soc_mdc_i, mdio_o=soc_mdio_o_i, mdio_oe_o=soc_mdio_oe_i.
- ERROR: err_o=1, busy_o=0, phy_rst_no=1. Pins stay owned by the block: mdc_o=0, mdio_oe_o=0.
- restart_i:
  - In DONE or ERROR -> RST_HOLD. Clears done_o/err_o the next cycle; phy_id_o is kept until the next read.
  - In any other state it is ignored.
- In every state other than DONE, SoC pin inputs are ignored.
- rst_n asserted mid-frame: all outputs return to reset values immediately (asynchronous); the sequence restarts from RST_HOLD.
- Counter widths are $clog2 of each parameter maximum (minimum 1 bit); no wrap beyond the terminal count.

Test Plan:
- Bench parameters: ClkDiv=2, RstHoldCycles=10, RstWaitCycles=5, PhyAddr=5'd3, default InitTable.
- Reset timing: release rst_n -> phy_rst_no low for exactly 10 cycles, then high; first MDC rising edge 5+2 cycles later; busy_o=1 throughout.
- Read frame: PHY model drives 16'h0141 on bits 48..63 -> sampled stream 32x1,01,10,00011,00010; mdio_oe_o low from bit 46; phy_id_o=16'h0141; error stays 0.
- Write frames: decode two frames -> {01,01,00011,00000,10,16'h1140}, then {01,01,00011,10000,10,16'h0000}; one idle MDC period between frames; done_o rises after the second frame.
- No PHY: mdio_i held 1 -> phy_id_o=16'hFFFF; err_o=1, done_o=0; mdc_o stays 0; no write frames.
- Handover and restart:
  - In DONE, toggle soc_mdc_i/soc_mdio_o_i/soc_mdio_oe_i -> same-cycle copy on the pins.
  - restart_i pulse -> phy_rst_no=0 the next cycle; done_o clears; full sequence repeats.
  - restart_i pulsed mid-frame -> ignored.
- Async reset during write frame bit 30 -> outputs reach reset values without a clock edge; sequence reruns fully.
